// File: rtl/controle_movimento.sv
// Frame-synchronous movement controller: debounces the four buttons, steps the
// object once per frame, clamps it to the visible area and rolls it back after
// an obstacle overlap seen during the previous frame.
module controle_movimento #(
    parameter int unsigned OBJ_SIZE   = 30,
    parameter int unsigned H_MAX      = 640,
    parameter int unsigned V_MAX      = 480,
    parameter int unsigned X_INIT     = 100,
    parameter int unsigned Y_INIT     = 20,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [3:0] KEY,
    input  logic [2:0] velocidade,
    input  logic       hit,
    output logic [9:0] xPos,
    output logic [8:0] yPos,
    output logic       moving,
    output logic       bump
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic signed [11:0] X_LIM = 12'(H_MAX - OBJ_SIZE);
    localparam logic signed [11:0] Y_LIM = 12'(V_MAX - OBJ_SIZE);

    typedef enum logic [1:0] {IDLE, EVAL, CLAMP, COMMIT} state_t;

    state_t              state;
    logic [3:0]          key_s1;
    logic [3:0]          key_s2;
    logic [3:0]          key_db;
    logic [CW-1:0]       deb_cnt [4];
    logic                hit_frame;
    logic signed [11:0]  dx;
    logic signed [11:0]  dy;
    logic [9:0]          nx;
    logic [8:0]          ny;
    logic [9:0]          prev_x;
    logic [8:0]          prev_y;
    logic signed [11:0]  sum_x_c;
    logic signed [11:0]  sum_y_c;
    logic [9:0]          clamp_x_c;
    logic [8:0]          clamp_y_c;
    logic signed [11:0]  vel_c;
    logic                right_c, left_c, up_c, down_c;

    // Two-flop synchronizer and per-key debounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            key_db <= '1;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    key_db[i]  <= key_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Remember any overlap during the frame; a hit in COMMIT survives into the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                hit_frame <= 1'b0;
        else if (hit)              hit_frame <= 1'b1;
        else if (state == COMMIT)  hit_frame <= 1'b0;
    end

    // Key decode, step size and clamped candidate position
    always_comb begin
        right_c   = ~key_db[0];
        left_c    = ~key_db[1];
        up_c      = ~key_db[2];
        down_c    = ~key_db[3];
        vel_c     = signed'(12'(velocidade));
        sum_x_c   = signed'(12'(xPos)) + dx;
        sum_y_c   = signed'(12'(yPos)) + dy;
        clamp_x_c = sum_x_c[9:0];
        clamp_y_c = sum_y_c[8:0];
        if (sum_x_c < 12'sd0)      clamp_x_c = '0;
        else if (sum_x_c > X_LIM)  clamp_x_c = 10'(X_LIM);
        if (sum_y_c < 12'sd0)      clamp_y_c = '0;
        else if (sum_y_c > Y_LIM)  clamp_y_c = 9'(Y_LIM);
    end

    // Frame step sequencer with registered position, moving and bump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dx     <= '0;
            dy     <= '0;
            nx     <= 10'(X_INIT);
            ny     <= 9'(Y_INIT);
            xPos   <= 10'(X_INIT);
            yPos   <= 9'(Y_INIT);
            prev_x <= 10'(X_INIT);
            prev_y <= 9'(Y_INIT);
            moving <= 1'b0;
            bump   <= 1'b0;
        end else begin
            bump <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) state <= EVAL;
                end
                EVAL: begin
                    if (right_c && !left_c)      dx <= vel_c;
                    else if (left_c && !right_c) dx <= -vel_c;
                    else                         dx <= '0;
                    if (down_c && !up_c)         dy <= vel_c;
                    else if (up_c && !down_c)    dy <= -vel_c;
                    else                         dy <= '0;
                    state <= CLAMP;
                end
                CLAMP: begin
                    nx    <= clamp_x_c;
                    ny    <= clamp_y_c;
                    state <= COMMIT;
                end
                COMMIT: begin
                    if (hit_frame) begin
                        xPos   <= prev_x;
                        yPos   <= prev_y;
                        bump   <= 1'b1;
                        moving <= (prev_x != xPos) || (prev_y != yPos);
                    end else begin
                        prev_x <= xPos;
                        prev_y <= yPos;
                        xPos   <= nx;
                        yPos   <= ny;
                        moving <= (nx != xPos) || (ny != yPos);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_movimento.sv
// Scoreboard bench for controle_movimento: stimulus pushes expected commits,
// a monitor pops them at the commit edge and compares.
module tb_controle_movimento;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [3:0] KEY;
    logic [2:0] velocidade;
    logic       hit;
    logic [9:0] xPos;
    logic [8:0] yPos;
    logic       moving;
    logic       bump;

    controle_movimento #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .KEY(KEY),
        .velocidade(velocidade), .hit(hit), .xPos(xPos), .yPos(yPos),
        .moving(moving), .bump(bump)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ox; int oy; int x; int y; bit mv; bit bp; bit abort;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int       mx, my, px, py;
    bit [3:0] mkeys;
    bit       hit_pend;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        mx = 100; my = 20; px = 100; py = 20; mkeys = 4'hF; hit_pend = 0;
    endtask

    // One frame step computed from the movement rules
    task automatic model_frame(input bit abort);
        exp_t e;
        int dxm, dym, nxm, nym;
        bit r, l, u, d;
        e.ox = mx; e.oy = my; e.abort = abort;
        r = !mkeys[0]; l = !mkeys[1]; u = !mkeys[2]; d = !mkeys[3];
        dxm = (r && !l) ? int'(velocidade) : (l && !r) ? -int'(velocidade) : 0;
        dym = (d && !u) ? int'(velocidade) : (u && !d) ? -int'(velocidade) : 0;
        if (hit_pend) begin
            e.x = px; e.y = py; e.bp = 1;
            e.mv = (px != mx) || (py != my);
            mx = px; my = py; hit_pend = 0;
        end else begin
            nxm = mx + dxm; nym = my + dym;
            if (nxm < 0) nxm = 0; if (nxm > 610) nxm = 610;
            if (nym < 0) nym = 0; if (nym > 450) nym = 450;
            e.x = nxm; e.y = nym; e.bp = 0;
            e.mv = (nxm != mx) || (nym != my);
            px = mx; py = my; mx = nxm; my = nym;
        end
        if (!abort) exp_q.push_back(e);
    endtask

    task automatic do_frame(input bit dbl);
        @(negedge clk); frame_tick = 1'b1; model_frame(1'b0);
        @(negedge clk); frame_tick = dbl;
        @(negedge clk); frame_tick = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic set_keys(input logic [3:0] k);
        @(negedge clk); KEY = k;
        repeat (DEB + 6) @(negedge clk);
        mkeys = k;
    endtask

    task automatic glitch(input int b);
        @(negedge clk); KEY[b] = 1'b0;
        repeat (2) @(negedge clk); KEY[b] = 1'b1;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic pulse_hit();
        @(negedge clk); hit = 1'b1;
        @(negedge clk); hit = 1'b0;
        hit_pend = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, int'(xPos), 100);
        chk({tag, "_y"}, int'(yPos), 20);
        chk({tag, "_moving"}, int'(moving), 0);
        chk({tag, "_bump"}, int'(bump), 0);
    endtask

    // Monitor: on an accepted tick, check hold at k+2, commit at k+3, bump low at k+4
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (frame_tick && rst_n) begin
                repeat (2) @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                    e.abort = 1;
                end else begin
                    e = exp_q.pop_front();
                end
                if (!e.abort) begin
                    chk("hold_x", int'(xPos), e.ox);
                    chk("hold_y", int'(yPos), e.oy);
                end
                @(posedge clk); #1;
                if (!e.abort) begin
                    chk("commit_x", int'(xPos), e.x);
                    chk("commit_y", int'(yPos), e.y);
                    chk("commit_moving", int'(moving), int'(e.mv));
                    chk("commit_bump", int'(bump), int'(e.bp));
                end
                @(posedge clk); #1;
                chk("bump_low", int'(bump), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        KEY = 4'hF; velocidade = 3'd0; hit = 1'b0; frame_tick = 1'b0; rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // No keys: position holds
        repeat (3) do_frame(1'b0);

        // Right held at speed 3
        velocidade = 3'd3;
        set_keys(4'b1110);
        repeat (5) do_frame(1'b0);

        // Short glitch on left has no effect; right+left cancel
        set_keys(4'b1111);
        glitch(1);
        do_frame(1'b0);
        set_keys(4'b1100);
        do_frame(1'b0);

        // Move, hit, roll back, move again
        velocidade = 3'd5;
        set_keys(4'b1110);
        do_frame(1'b0);
        pulse_hit();
        do_frame(1'b0);
        do_frame(1'b0);

        // Right boundary: reach 608, then clamp at 610
        velocidade = 3'd7;
        while (mx + 7 <= 608) do_frame(1'b0);
        if (mx < 608) begin velocidade = 3'(608 - mx); do_frame(1'b0); end
        velocidade = 3'd7;
        do_frame(1'b0);
        do_frame(1'b1);

        // Top boundary: reach 2, then clamp at 0
        set_keys(4'b1011);
        while (my - 2 > 7) do_frame(1'b0);
        if (my > 2) begin velocidade = 3'(my - 2); do_frame(1'b0); end
        velocidade = 3'd7;
        do_frame(1'b0);
        do_frame(1'b0);

        // Reset one cycle after a tick aborts the step
        velocidade = 3'd3;
        set_keys(4'b1110);
        @(negedge clk); frame_tick = 1'b1;
        exp_q.push_back('{ox: 0, oy: 0, x: 0, y: 0, mv: 0, bp: 0, abort: 1});
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        model_reset();
        repeat (2) @(negedge clk); rst_n = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        mkeys = KEY;
        do_frame(1'b0);

        // Randomized mix of key changes, speeds, glitches, hits and frames
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: set_keys(4'($urandom_range(0, 15)));
                1: velocidade = 3'($urandom_range(0, 7));
                2: begin
                    int b;
                    b = $urandom_range(0, 3);
                    if (mkeys[b] && KEY[b]) glitch(b);
                end
                3: pulse_hit();
                default: do_frame(1'($urandom_range(0, 1)));
            endcase
        end
        do_frame(1'b0);

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controle_movimento.md
# controle_movimento

Frame-synchronous movement controller for the VGA moving-object path. It debounces the four push-buttons and applies one step per video frame, at the speed selected by `velocidade`. It clamps the object inside the visible area and rolls the object back when the drawn object overlapped an obstacle during the previous frame. It owns the `xPos`/`yPos` registers consumed by the object-drawing and collision blocks, so they never change during active video.

## Interface
- `OBJ_SIZE`, 30, object side in pixels
- `H_MAX`, 640, visible columns
- `V_MAX`, 480, visible rows
- `X_INIT`, 100, reset column
- `Y_INIT`, 20, reset row
- `DEB_CYCLES`, 250000, stable cycles required to accept a key change (≥2)

- `clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per frame, issued in vertical blanking
- `KEY`  in  4  raw buttons, active-low, asynchronous: [0] right, [1] left, [2] up, [3] down
- `velocidade`  in  3  pixels per step, 0..7; 0 = hold
- `hit`  in  1  current pixel is both object and obstacle
- `xPos`  out  10  object left column
- `yPos`  out  9  object top row
- `moving`  out  1  last commit changed the position
- `bump`  out  1  one-cycle pulse on a rollback commit

## Operation
- Each `KEY` bit passes through a 2-FF synchronizer, then a debouncer. The debouncer counter clears whenever the synchronized value equals the stable value. The stable value takes the synchronized value once the counter reaches `DEB_CYCLES-1`.
- A key is pressed when its stable value is 0.
- `hit_frame` sets on any cycle with `hit`=1. It clears only in COMMIT. A `hit` in the COMMIT cycle itself sets `hit_frame` for the next frame, because set wins over clear.
- FSM states: IDLE, EVAL, CLAMP, COMMIT.
  - IDLE: waits for `frame_tick`=1, then goes to EVAL.
  - EVAL: computes `dx`/`dy` as signed 12-bit values, each ±`velocidade` or 0.
    - right with left gives `dx`=0; up with down gives `dy`=0.
    - Then goes to CLAMP.
  - CLAMP: forms `nx = xPos+dx` and `ny = yPos+dy` in signed 12 bits.
    - Values below 0 become 0.
    - `nx` above `H_MAX-OBJ_SIZE` becomes `H_MAX-OBJ_SIZE` (610).
    - `ny` above `V_MAX-OBJ_SIZE` becomes `V_MAX-OBJ_SIZE` (450).
    - Then goes to COMMIT.
  - COMMIT with `hit_frame`=1:
    - `xPos`/`yPos` ← `prev_x`/`prev_y`.
    - `bump`=1 for one cycle.
    - `moving` = (restored position ≠ current position).
  - COMMIT with `hit_frame`=0:
    - `prev_x`/`prev_y` ← `xPos`/`yPos`.
    - `xPos`/`yPos` ← `nx`/`ny`.
    - `moving` = (new ≠ old).
  - COMMIT always returns to IDLE.
- `frame_tick` outside IDLE is ignored; no queuing.
- A position never leaves [0,610]×[0,450]. No wrap-around.

## Timing
- Reset (async assert, sync-free deassert):
  - `xPos`=`X_INIT`, `yPos`=`Y_INIT`, `prev`=same.
  - `moving`=0, `bump`=0, `hit_frame`=0.
  - Debounced keys = 1 (released); counters = 0; state IDLE.
- Reset asserted mid-sequence (EVAL/CLAMP/COMMIT) aborts the step; the reset values above apply immediately.
- Edge k samples `frame_tick`=1 (IDLE→EVAL). Edge k+1 enters CLAMP, edge k+2 enters COMMIT. Edge k+3 updates `xPos`, `yPos`, `moving` and `bump` and returns to IDLE.
  - Latency is 3 clocks.
  - `bump` deasserts at k+4.
- The positions change only at a COMMIT edge, so they are stable for the whole active frame.
- Key latency from a `KEY` edge to the debounced change: 2 sync + `DEB_CYCLES` clocks. A glitch shorter than `DEB_CYCLES` has no effect.
- `velocidade` and the debounced keys are sampled in EVAL only.

## Test plan
- Reset with `X_INIT`=100 and `Y_INIT`=20, then release reset and apply 3 `frame_tick`s with no keys → `xPos`=100, `yPos`=20, `moving`=0, `bump` never high.
- With `DEB_CYCLES`=4, hold `KEY[0]`=0, `velocidade`=3, and apply 5 `frame_tick`s → `xPos` reads 103, 106, …, 115. Each update lands exactly 3 clocks after its tick. `moving`=1.
- Apply a 2-cycle low glitch on `KEY[1]`, then a `frame_tick` → no position change. Separately, hold `KEY[0]` and `KEY[1]` low together → `dx`=0, `xPos` unchanged.
- Start at `xPos`=608 with right held and `velocidade`=7 → `xPos`=610, then stays 610 with `moving`=0. Start at `yPos`=2 with up held and `velocidade`=7 → `yPos`=0.
- Move from 100 to 105, then pulse `hit` for one cycle before the next tick → that commit restores `xPos`=100, `bump` pulses exactly 1 cycle, and the following tick moves to 105 again.
- Assert `rst_n`=0 one cycle after a `frame_tick` → outputs immediately return to 100/20 with `bump`=0. After release, the next tick produces a normal step.
